// File: rtl/shared_arb_pkg.sv
// Shared definitions for the shared-register arbiter: FSM encoding,
// default data width and a modulo-increment helper for the round-robin pointer.
package shared_arb_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // (idx + 1) mod n, for idx already in 0..n-1
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/shared_reg_arb_flopenr.sv
// N-bit register with load enable and asynchronous active-high clear.
module flopenr
  import shared_arb_pkg::*;
#(
  parameter int unsigned N = DEF_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/shared_reg_arb.sv
// Round-robin arbiter granting exclusive, time-limited write access to one
// shared register among NREQ requesters.
module shared_reg_arb
  import shared_arb_pkg::*;
#(
  parameter int unsigned N        = DEF_WIDTH,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*N-1:0]        wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy,
  output logic [N-1:0]             q
);

  localparam int unsigned OW = $clog2(NREQ);
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  arb_state_e      state_q;
  logic [NREQ-1:0] gnt_q;
  logic [OW-1:0]   owner_q;
  logic            busy_q;
  logic [OW-1:0]   ptr_q;
  logic [HW-1:0]   hold_q;

  logic            win_found_c;
  logic [OW-1:0]   win_idx_c;
  int              cand;
  logic            req_own_c;
  logic [N-1:0]    owner_wdata_c;
  logic            wr_en_c;
  logic [HW-1:0]   hold_inc_c;
  logic [OW-1:0]   next_ptr_c;
  logic            release_c;

  // Round-robin search: walk from the farthest offset down so the nearest
  // requester at or after ptr is the last (and winning) assignment.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    cand        = 0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      cand = int'(ptr_q) + k;
      if (cand >= int'(NREQ)) begin
        cand = cand - int'(NREQ);
      end
      if (req[OW'(cand)]) begin
        win_found_c = 1'b1;
        win_idx_c   = OW'(cand);
      end
    end
  end

  // Owner's request bit and write data, selected by the registered owner
  always_comb begin
    req_own_c     = 1'b0;
    owner_wdata_c = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (owner_q == OW'(i)) begin
        req_own_c     = req[i];
        owner_wdata_c = wdata[i*N +: N];
      end
    end
  end

  assign wr_en_c    = (state_q == GRANT) && req_own_c;
  assign hold_inc_c = hold_q + HW'(1);
  assign next_ptr_c = OW'(wrap_inc(32'(owner_q), NREQ));
  // Grant ends when the owner lets go or on the write that reaches the limit
  assign release_c  = !req_own_c || (hold_inc_c == HW'(MAX_HOLD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found_c) begin
            state_q <= GRANT;
            gnt_q   <= NREQ'(1) << win_idx_c;
            owner_q <= win_idx_c;
            busy_q  <= 1'b1;
            hold_q  <= '0;
          end
        end
        GRANT: begin
          if (wr_en_c) begin
            hold_q <= hold_inc_c;
          end
          if (release_c) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= next_ptr_c;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  flopenr #(
    .N(N)
  ) u_shared_q (
    .clk (clk),
    .rst (rst),
    .en_i(wr_en_c),
    .d_i (owner_wdata_c),
    .q_o (q)
  );

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_shared_reg_arb.sv
// Self-checking bench for shared_reg_arb: directed scenarios plus randomized
// traffic compared against a behavioural arbitration model.
module tb_shared_reg_arb;

  localparam int N        = 32;
  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 8;

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         req;
  logic [NREQ*N-1:0]       wdata;
  logic [NREQ-1:0]         gnt;
  logic [$clog2(NREQ)-1:0] owner;
  logic                    busy;
  logic [N-1:0]            q;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit           m_busy;
  int           m_owner;
  int           m_ptr;
  int           m_writes;
  logic [N-1:0] m_q;

  shared_reg_arb #(
    .N(N), .NREQ(NREQ), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(gnt), .owner(owner), .busy(busy), .q(q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ*N-1:0] rand_wd();
    logic [NREQ*N-1:0] w;
    for (int i = 0; i < NREQ; i++) w[i*N +: N] = $urandom();
    return w;
  endfunction

  task automatic model_clear();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_writes = 0; m_q = '0;
  endtask

  task automatic model_edge(input logic [NREQ-1:0] r, input logic [NREQ*N-1:0] wd);
    int p;
    if (!m_busy) begin
      p = rr_pick(m_ptr, r);
      if (p >= 0) begin
        m_busy = 1; m_owner = p; m_writes = 0;
      end
    end else if (r[m_owner]) begin
      m_q = wd[m_owner*N +: N];
      m_writes++;
      if (m_writes == MAX_HOLD) begin
        m_busy = 0; m_ptr = (m_owner + 1) % NREQ;
      end
    end else begin
      m_busy = 0; m_ptr = (m_owner + 1) % NREQ;
    end
  endtask

  // Drive inputs, take one rising edge, advance the model, settle 1 time unit
  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*N-1:0] wd);
    req = r; wdata = wd;
    @(posedge clk);
    if (rst) model_clear(); else model_edge(r, wd);
    #1;
  endtask

  // Assert reset between edges, hold it across one edge, release
  task automatic apply_reset();
    #3 rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    req = '0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (gnt !== '0 || busy !== 1'b0 || q !== '0 || owner !== '0) begin
      errors++;
      $display("FAIL reset_initial: gnt=%b busy=%b q=%h owner=%0d, want all zero", gnt, busy, q, owner);
    end
    @(posedge clk); #1 rst = 1'b0;
    model_clear();
    step(4'b1111, rand_wd());
    checks++;
    if (gnt !== 4'b0001 || owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_first_prio: gnt=%b owner=%0d, want 0001 owner 0", gnt, owner);
    end
    step(4'b1111, rand_wd());
    #3 rst = 1'b1;
    #1;
    model_clear();
    checks++;
    if (gnt !== '0 || busy !== 1'b0 || q !== '0 || owner !== '0) begin
      errors++;
      $display("FAIL reset_async: gnt=%b busy=%b q=%h owner=%0d, want all zero", gnt, busy, q, owner);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single();
    logic [NREQ*N-1:0] wd;
    apply_reset();
    wd = rand_wd();
    wd[2*N +: N] = 32'hA5A5_0001;
    step(4'b0100, wd);
    checks++;
    if (gnt !== 4'b0100 || owner !== 2'd2 || busy !== 1'b1 || q !== '0) begin
      errors++;
      $display("FAIL single_grant: gnt=%b owner=%0d busy=%b q=%h, want 0100 2 1 0", gnt, owner, busy, q);
    end
    step(4'b0100, wd);
    checks++;
    if (q !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL single_first_write: q=%h, want a5a50001", q);
    end
    step(4'b0100, wd);
    step(4'b0000, rand_wd());
    checks++;
    if (busy !== 1'b0 || gnt !== '0 || q !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL single_release: busy=%b gnt=%b q=%h, want 0 0000 a5a50001", busy, gnt, q);
    end
    step(4'b0000, rand_wd());
    checks++;
    if (busy !== 1'b0 || q !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL single_idle_hold: busy=%b q=%h, want 0 a5a50001", busy, q);
    end
    step(4'b1111, rand_wd());
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL single_ptr_next: gnt=%b, want 1000", gnt);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int ngr  = 0;
    int idle = 0;
    logic prev_busy = 1'b0;
    logic [NREQ-1:0] r;
    logic [NREQ-1:0] exp_g;
    apply_reset();
    for (int c = 0; c < 40 && ngr < 5; c++) begin
      r = '1;
      if (m_busy && m_writes >= 1) r[m_owner] = 1'b0;
      step(r, rand_wd());
      if (busy && !prev_busy) begin
        exp_g = '0;
        exp_g[order[ngr]] = 1'b1;
        checks++;
        if (gnt !== exp_g) begin
          errors++;
          $display("FAIL rr_order%0d: gnt=%b, want %b", ngr, gnt, exp_g);
        end
        if (ngr > 0) begin
          checks++;
          if (idle != 1) begin
            errors++;
            $display("FAIL rr_idle_gap%0d: idle cycles=%0d, want 1", ngr, idle);
          end
        end
        ngr++;
        idle = 0;
      end else if (!busy) begin
        idle++;
      end
      prev_busy = busy;
    end
    checks++;
    if (ngr != 5) begin
      errors++;
      $display("FAIL rr_grant_count: grants=%0d, want 5", ngr);
    end
  endtask

  task automatic test_hold_limit();
    logic [NREQ*N-1:0] wd;
    logic [N-1:0] prevq;
    int v  = 1;
    int nw = 0;
    apply_reset();
    wd = rand_wd();
    wd[N +: N] = 32'(v);
    step(4'b0010, wd);
    prevq = q;
    for (int c = 0; c < 20 && busy; c++) begin
      wd[N +: N] = 32'(v);
      step(4'b0010, wd);
      if (q !== prevq) begin
        nw++;
        v++;
      end
      prevq = q;
    end
    checks++;
    if (nw != MAX_HOLD || q !== 32'd8) begin
      errors++;
      $display("FAIL hold_writes: writes=%0d q=%h, want 8 writes q=00000008", nw, q);
    end
    checks++;
    if (busy !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL hold_forced_idle: busy=%b gnt=%b, want 0 0000", busy, gnt);
    end
    step(4'b0011, rand_wd());
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL hold_ptr_after_limit: gnt=%b, want 0001", gnt);
    end
  endtask

  task automatic test_isolation();
    logic [NREQ*N-1:0] wd;
    apply_reset();
    wd = rand_wd();
    wd[0 +: N]   = 32'h11;
    wd[3*N +: N] = 32'hFF;
    step(4'b1001, wd);
    checks++;
    if (owner !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL iso_grant: owner=%0d busy=%b, want 0 1", owner, busy);
    end
    for (int c = 0; c < 5; c++) begin
      step(4'b1001, wd);
      checks++;
      if (q === 32'hFF || q !== 32'h11 || owner !== 2'd0) begin
        errors++;
        $display("FAIL iso_cycle%0d: q=%h owner=%0d, want q=00000011 owner 0", c, q, owner);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [NREQ*N-1:0] wd;
    apply_reset();
    wd = rand_wd();
    wd[N +: N] = 32'h101;
    step(4'b0010, wd);
    step(4'b0010, wd);
    wd[N +: N] = 32'h102;
    step(4'b0010, wd);
    wd[N +: N] = 32'h103;
    req = 4'b0010; wdata = wd;
    #3 rst = 1'b1;
    #1;
    model_clear();
    checks++;
    if (gnt !== '0 || busy !== 1'b0 || q !== '0) begin
      errors++;
      $display("FAIL arst_immediate: gnt=%b busy=%b q=%h, want 0000 0 0", gnt, busy, q);
    end
    @(posedge clk); #1;
    checks++;
    if (q !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL arst_write_discarded: q=%h busy=%b, want 0 0", q, busy);
    end
    rst = 1'b0;
    step(4'b1010, rand_wd());
    checks++;
    if (gnt !== 4'b0010 || owner !== 2'd1) begin
      errors++;
      $display("FAIL arst_regrant: gnt=%b owner=%0d, want 0010 owner 1", gnt, owner);
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] r;
    logic [NREQ-1:0] exp_g;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      r = NREQ'($urandom_range(0, 15));
      if (m_busy && $urandom_range(0, 4) != 0) r[m_owner] = 1'b1;
      step(r, rand_wd());
      exp_g = '0;
      if (m_busy) exp_g[m_owner] = 1'b1;
      checks++;
      if (gnt !== exp_g || busy !== m_busy || q !== m_q) begin
        errors++;
        $display("FAIL rand_cycle%0d: gnt=%b busy=%b q=%h, want %b %b %h", c, gnt, busy, q, exp_g, m_busy, m_q);
      end
      if (m_busy) begin
        checks++;
        if (owner !== 2'(m_owner)) begin
          errors++;
          $display("FAIL rand_owner%0d: owner=%0d, want %0d", c, owner, m_owner);
        end
      end
      if ($urandom_range(0, 59) == 0) begin
        #3 rst = 1'b1;
        #1;
        model_clear();
        checks++;
        if (gnt !== '0 || busy !== 1'b0 || q !== '0) begin
          errors++;
          $display("FAIL rand_arst%0d: gnt=%b busy=%b q=%h, want all zero", c, gnt, busy, q);
        end
        @(posedge clk); #1 rst = 1'b0;
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    wdata = '0;
    model_clear();
    test_reset();
    test_single();
    test_round_robin();
    test_hold_limit();
    test_isolation();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shared_reg_arb.md
SHARED_REG_ARB -- requirements
Module: shared_reg_arb

Interface
REQ-001 SHALL have parameter N, default 32: data width of the shared register.
REQ-002 SHALL have parameter NREQ, default 4: number of requesters, legal range 2..8.
REQ-003 SHALL have parameter MAX_HOLD, default 8: maximum write cycles per grant, legal range 1..255.
REQ-004 Ports:
- clk  input  1  — single clock; all state updates on the rising edge.
- rst  input  1  — reset, asynchronous, active-high.
- req  input  NREQ  — per-requester request and write strobe.
- wdata  input  NREQ*N  — packed write data; requester i owns bits [i*N +: N].
- gnt  output  NREQ  — registered one-hot grant, or all zeros.
- owner  output  clog2(NREQ)  — index of the granted requester; valid only while busy=1.
- busy  output  1  — high while in GRANT.
- q  output  N  — shared register contents.

Function
REQ-005 SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-006 In IDLE with req nonzero, SHALL select a winner by round-robin: the lowest index at or after ptr, searching modulo NREQ; the next edge loads gnt=onehot(winner), owner=winner, busy=1, state=GRANT, hold=0.
REQ-007 In IDLE with req==0, SHALL keep gnt=0 and busy=0, and q SHALL hold its value.
REQ-008 In GRANT, each edge with req[owner]=1 SHALL load q<=wdata[owner] and increment hold; q is visible one cycle after the write edge.
REQ-009 In GRANT, SHALL ignore wdata and req of non-owners; q SHALL never change from a non-owner.
REQ-010 In GRANT, an edge with req[owner]=0 SHALL perform no write and return to IDLE with gnt=0, busy=0, ptr=(owner+1) mod NREQ.
REQ-011 The edge performing write number MAX_HOLD SHALL also force a return to IDLE with ptr=(owner+1) mod NREQ, even if req[owner] stays high.
REQ-012 SHALL spend at least one IDLE cycle between consecutive grants, so one grant never directly follows another.
REQ-013 Latency: req rising in IDLE → gnt high after 1 edge → first write on the following edge → q updated 2 edges after the request.
REQ-014 hold SHALL be ceil(log2(MAX_HOLD+1)) bits and SHALL never wrap.
REQ-015 gnt SHALL never have more than one bit set, and SHALL be nonzero exactly when busy=1.

Reset
REQ-016 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, gnt=0, owner=0, busy=0, q=0, ptr=0, hold=0.
REQ-017 rst asserted mid-grant SHALL abort the grant and discard any write pending on that cycle.
REQ-018 After rst is released, the first arbitration SHALL give priority to requester 0.

Structure
REQ-019 SHALL place the state encoding (IDLE, GRANT) and a default-width constant in a shared package, shared_arb_pkg.
REQ-020 SHALL hold q in one sub-module, flopenr: an N-bit register with enable and asynchronous active-high reset to 0.
REQ-021 The round-robin search SHALL be combinational inside shared_reg_arb; all outputs SHALL be registered.

Verification
REQ-022 Reset then single requester:
- stimulus: rst pulse; req=0b0100, wdata[2]=0xA5A5_0001 for 3 cycles, then req=0.
- response: gnt=0b0100, owner=2 at edge 1; q=0xA5A5_0001 from edge 2; IDLE and ptr=3 after req drops.
REQ-023 Round-robin fairness:
- stimulus: req=0b1111 held; each requester drops req after 1 write.
- response: grant order 0,1,2,3,0; exactly one IDLE cycle between grants.
REQ-024 Hold limit:
- stimulus: MAX_HOLD=8; req[1] held high; wdata[1] increments 1..12.
- response: exactly 8 writes, q=8; forced IDLE; requester 1 regranted only after 2, 3, 0 are checked.
REQ-025 Non-owner isolation:
- stimulus: owner=0 writing 0x11; req[3] high with wdata[3]=0xFF.
- response: q never shows 0xFF while owner=0.
REQ-026 Asynchronous reset mid-grant:
- stimulus: rst asserted between clock edges during the 3rd write of owner 1.
- response: gnt=0, busy=0, q=0 immediately; after release, req=0b1010 grants requester 1 before 3.
